// File: rtl/issue_scheduler.sv
// Single-issue scheduler: register scoreboard for RAW/WAW hazards, a non-pipelined
// FPU countdown, and arbitration of the one register-file write port.
module issue_scheduler #(
    parameter int unsigned FPU_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    output logic       dec_ready,
    input  logic [4:0] dec_rd_addr,
    input  logic [4:0] dec_rs1_addr,
    input  logic [4:0] dec_rs2_addr,
    input  logic       dec_use_alu,
    input  logic       dec_use_fpu,
    input  logic       dec_operand_a_enable,
    input  logic       dec_operand_b_enable,
    input  logic       dec_rd_is_operand_a,
    input  logic       dec_result_enable,
    output logic       alu_issue,
    output logic       fpu_issue,
    output logic       wb_valid,
    output logic [4:0] wb_rd_addr,
    output logic       wb_from_fpu,
    output logic       fpu_busy,
    output logic       busy
);

    localparam logic [3:0] FPU_LOAD = 4'(FPU_LATENCY - 1);

    logic [31:0] sb_q, sb_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fbusy_q, fbusy_d;
    logic [4:0]  frd_q, frd_d;
    logic        fwe_q, fwe_d;
    logic        wbv_q, wbv_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic        wbf_q, wbf_d;

    logic        to_fpu, to_alu;
    logic [4:0]  src_a;
    logic [31:0] clr_mask, set_mask, pending;
    logic        fpu_wb_now, fpu_wb_next;
    logic        stall, ready, issue, alu_wb;

    always_comb begin
        to_fpu = dec_use_fpu;
        to_alu = (dec_use_alu & ~dec_use_fpu) | (~dec_use_alu & ~dec_use_fpu);
        src_a  = dec_rd_is_operand_a ? dec_rd_addr : dec_rs1_addr;

        // Write-first register file: the register written back this cycle is no longer pending.
        clr_mask = wbv_q ? (32'd1 << wbrd_q) : '0;
        pending  = sb_q & ~clr_mask;

        // The countdown reaches zero in the FPU writeback cycle; one means writeback next cycle.
        fpu_wb_now  = fbusy_q && (cnt_q == 4'd0);
        fpu_wb_next = fbusy_q && (cnt_q == 4'd1) && fwe_q;

        stall = (dec_operand_a_enable && pending[src_a])
              || (dec_operand_b_enable && pending[dec_rs2_addr])
              || (dec_result_enable && pending[dec_rd_addr])
              || (to_fpu && fbusy_q && !fpu_wb_now)
              || (to_alu && dec_result_enable && fpu_wb_next);

        ready  = !rst && !stall;
        issue  = dec_valid && ready;
        alu_wb = issue && to_alu && dec_result_enable;

        set_mask = (issue && dec_result_enable) ? (32'd1 << dec_rd_addr) : '0;
        sb_d     = (sb_q & ~clr_mask) | set_mask;

        fbusy_d = fbusy_q;
        cnt_d   = cnt_q;
        frd_d   = frd_q;
        fwe_d   = fwe_q;
        if (issue && to_fpu) begin
            fbusy_d = 1'b1;
            cnt_d   = FPU_LOAD;
            frd_d   = dec_rd_addr;
            fwe_d   = dec_result_enable;
        end else if (fpu_wb_now) begin
            fbusy_d = 1'b0;
        end else if (fbusy_q) begin
            cnt_d = cnt_q - 4'd1;
        end

        wbv_d  = alu_wb || fpu_wb_next;
        wbf_d  = fpu_wb_next;
        wbrd_d = wbrd_q;
        if (alu_wb) begin
            wbrd_d = dec_rd_addr;
        end else if (fpu_wb_next) begin
            wbrd_d = frd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q    <= '0;
            cnt_q   <= '0;
            fbusy_q <= 1'b0;
            frd_q   <= '0;
            fwe_q   <= 1'b0;
            wbv_q   <= 1'b0;
            wbrd_q  <= '0;
            wbf_q   <= 1'b0;
        end else begin
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            fbusy_q <= fbusy_d;
            frd_q   <= frd_d;
            fwe_q   <= fwe_d;
            wbv_q   <= wbv_d;
            wbrd_q  <= wbrd_d;
            wbf_q   <= wbf_d;
        end
    end

    assign dec_ready   = ready;
    assign alu_issue   = issue && to_alu;
    assign fpu_issue   = issue && to_fpu;
    assign wb_valid    = wbv_q;
    assign wb_rd_addr  = wbrd_q;
    assign wb_from_fpu = wbf_q;
    assign fpu_busy    = fbusy_q;
    assign busy        = (|sb_q) | fbusy_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table plus randomized traffic against
// an event-queue reference model that tracks writebacks by absolute cycle number.
module tb_issue_scheduler;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_ready;
    logic [4:0] dec_rd_addr, dec_rs1_addr, dec_rs2_addr;
    logic       dec_use_alu, dec_use_fpu;
    logic       dec_operand_a_enable, dec_operand_b_enable;
    logic       dec_rd_is_operand_a, dec_result_enable;
    logic       alu_issue, fpu_issue, wb_valid, wb_from_fpu, fpu_busy, busy;
    logic [4:0] wb_rd_addr;

    always #5 clk = ~clk;

    issue_scheduler #(.FPU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rd_addr(dec_rd_addr), .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_use_alu(dec_use_alu), .dec_use_fpu(dec_use_fpu),
        .dec_operand_a_enable(dec_operand_a_enable), .dec_operand_b_enable(dec_operand_b_enable),
        .dec_rd_is_operand_a(dec_rd_is_operand_a), .dec_result_enable(dec_result_enable),
        .alu_issue(alu_issue), .fpu_issue(fpu_issue),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_from_fpu(wb_from_fpu),
        .fpu_busy(fpu_busy), .busy(busy)
    );

    typedef struct {
        bit       rst, v;
        bit [4:0] rd, rs1, rs2;
        bit       fpu, a_en, b_en, rd_a, res;
        bit       chk, e_ready, e_wbv;
        bit [4:0] e_wbrd;
        bit       e_wbf, e_fbusy;
    } vec_t;

    typedef struct {
        int t;
        int rd;
        bit fpu;
    } wb_ev_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [31:0] m_sb;
    wb_ev_t    m_ev[$];
    int        m_t, m_fb_from, m_fb_to;
    bit [4:0]  m_last_rd;

    function automatic vec_t mk(bit v, int rd, int rs1, int rs2, bit fpu, bit a_en, bit b_en,
                                bit rd_a, bit res, bit chk, bit e_ready, bit e_wbv,
                                int e_wbrd, bit e_wbf, bit e_fbusy);
        vec_t r;
        r.rst = 1'b0; r.v = v; r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
        r.fpu = fpu; r.a_en = a_en; r.b_en = b_en; r.rd_a = rd_a; r.res = res;
        r.chk = chk; r.e_ready = e_ready; r.e_wbv = e_wbv; r.e_wbrd = 5'(e_wbrd);
        r.e_wbf = e_wbf; r.e_fbusy = e_fbusy;
        return r;
    endfunction

    function automatic vec_t idle(bit e_wbv, int e_wbrd, bit e_wbf, bit e_fbusy);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, e_wbv, e_wbrd, e_wbf, e_fbusy);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sb = '0;
        m_ev.delete();
        m_fb_from = 0;
        m_fb_to = -1;
        m_last_rd = '0;
    endtask

    task automatic step(input vec_t r, input string tag);
        bit       m_wbv, m_wbf, due_next, m_fbusy, stall, m_ready, issued;
        bit [4:0] m_wbrd, src_a;
        bit [31:0] pend;
        @(negedge clk);
        rst = r.rst;
        dec_valid = r.v; dec_rd_addr = r.rd; dec_rs1_addr = r.rs1; dec_rs2_addr = r.rs2;
        dec_use_fpu = r.fpu; dec_use_alu = ~r.fpu;
        dec_operand_a_enable = r.a_en; dec_operand_b_enable = r.b_en;
        dec_rd_is_operand_a = r.rd_a; dec_result_enable = r.res;
        #1;
        m_wbv = 0; m_wbf = 0; m_wbrd = m_last_rd; due_next = 0;
        foreach (m_ev[i]) begin
            if (m_ev[i].t == m_t) begin
                m_wbv = 1; m_wbrd = 5'(m_ev[i].rd); m_wbf = m_ev[i].fpu;
            end
            if (m_ev[i].t == m_t + 1 && m_ev[i].fpu) due_next = 1;
        end
        m_fbusy = (m_t >= m_fb_from) && (m_t <= m_fb_to);
        pend = m_sb;
        if (m_wbv) pend[m_wbrd] = 1'b0;
        src_a = r.rd_a ? r.rd : r.rs1;
        stall = (r.a_en && pend[src_a]) || (r.b_en && pend[r.rs2]) || (r.res && pend[r.rd])
              || (r.fpu && m_fbusy && (m_t != m_fb_to))
              || (!r.fpu && r.res && due_next);
        m_ready = !stall;
        if (!r.rst) begin
            check({tag, " ready"}, int'(dec_ready), int'(m_ready));
            check({tag, " alu_issue"}, int'(alu_issue), int'(r.v && m_ready && !r.fpu));
            check({tag, " fpu_issue"}, int'(fpu_issue), int'(r.v && m_ready && r.fpu));
            check({tag, " wb_valid"}, int'(wb_valid), int'(m_wbv));
            check({tag, " wb_rd"}, int'(wb_rd_addr), int'(m_wbrd));
            if (m_wbv) check({tag, " wb_from_fpu"}, int'(wb_from_fpu), int'(m_wbf));
            check({tag, " fpu_busy"}, int'(fpu_busy), int'(m_fbusy));
            check({tag, " busy"}, int'(busy), int'((m_sb != 0) || m_fbusy));
        end
        if (r.chk) begin
            check({tag, " tab_ready"}, int'(dec_ready), int'(r.e_ready));
            check({tag, " tab_wb_valid"}, int'(wb_valid), int'(r.e_wbv));
            check({tag, " tab_wb_rd"}, int'(wb_rd_addr), int'(r.e_wbrd));
            if (r.e_wbv) check({tag, " tab_wb_from_fpu"}, int'(wb_from_fpu), int'(r.e_wbf));
            check({tag, " tab_fpu_busy"}, int'(fpu_busy), int'(r.e_fbusy));
        end
        issued = r.v && m_ready && !r.rst;
        @(posedge clk);
        if (r.rst) begin
            model_reset();
        end else begin
            if (m_wbv) begin
                m_sb[m_wbrd] = 1'b0;
                m_last_rd = m_wbrd;
            end
            if (issued) begin
                if (r.res) m_sb[r.rd] = 1'b1;
                if (r.fpu) begin
                    m_fb_from = m_t + 1;
                    m_fb_to = m_t + LAT;
                    if (r.res) m_ev.push_back('{m_t + LAT, int'(r.rd), 1'b1});
                end else if (r.res) begin
                    m_ev.push_back('{m_t + 1, int'(r.rd), 1'b0});
                end
            end
        end
        m_t++;
        for (int i = m_ev.size() - 1; i >= 0; i--)
            if (m_ev[i].t < m_t) m_ev.delete(i);
    endtask

    function automatic bit [4:0] pick_reg();
        bit [4:0] r;
        r = {1'($urandom_range(0, 1)), 2'b00, 2'($urandom_range(0, 3))};
        return r;
    endfunction

    vec_t tab[$];
    vec_t rv;

    initial begin
        rst = 1'b1; dec_valid = 0; dec_rd_addr = 0; dec_rs1_addr = 0; dec_rs2_addr = 0;
        dec_use_alu = 0; dec_use_fpu = 0; dec_operand_a_enable = 0; dec_operand_b_enable = 0;
        dec_rd_is_operand_a = 0; dec_result_enable = 0;
        m_t = 0;
        model_reset();

        rv = idle(0, 0, 0, 0); rv.rst = 1; rv.chk = 0;
        tab.push_back(rv);
        tab.push_back(rv);
        tab.push_back(idle(0, 0, 0, 0));
        // RAW resolved by write-first writeback
        tab.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tab.push_back(mk(1, 4, 3, 0, 0, 1, 0, 0, 1, 1, 1, 1, 3, 0, 0));
        tab.push_back(idle(1, 4, 0, 0));
        tab.push_back(idle(0, 4, 0, 0));
        // ALU waits on FPU result rd=17
        tab.push_back(mk(1, 17, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 4, 0, 0));
        for (int i = 0; i < 3; i++)
            tab.push_back(mk(1, 6, 0, 17, 0, 0, 1, 0, 1, 1, 0, 0, 4, 0, 1));
        tab.push_back(mk(1, 6, 0, 17, 0, 0, 1, 0, 1, 1, 1, 1, 17, 1, 1));
        tab.push_back(idle(1, 6, 0, 0));
        // Back-to-back FPU ops
        tab.push_back(mk(1, 8, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 6, 0, 0));
        for (int i = 0; i < 3; i++)
            tab.push_back(mk(1, 9, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 6, 0, 1));
        tab.push_back(mk(1, 9, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 8, 1, 1));
        for (int i = 0; i < 3; i++) tab.push_back(idle(0, 8, 0, 1));
        tab.push_back(idle(1, 9, 1, 1));
        tab.push_back(idle(0, 9, 0, 0));
        // Port conflict: third ALU result op defers one cycle
        tab.push_back(mk(1, 20, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 9, 0, 0));
        tab.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 9, 0, 1));
        tab.push_back(mk(1, 11, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 10, 0, 1));
        tab.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 11, 0, 1));
        tab.push_back(mk(1, 12, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 20, 1, 1));
        tab.push_back(idle(1, 12, 0, 0));
        // Store is never blocked by the port conflict
        tab.push_back(mk(1, 21, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 12, 0, 0));
        tab.push_back(idle(0, 12, 0, 1));
        tab.push_back(idle(0, 12, 0, 1));
        tab.push_back(mk(1, 13, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 12, 0, 1));
        tab.push_back(idle(1, 21, 1, 1));
        tab.push_back(idle(0, 21, 0, 0));
        // rd_is_operand_a RAW and WAW on pending rd=5
        tab.push_back(mk(1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 21, 0, 0));
        tab.push_back(mk(1, 5, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 21, 0, 1));
        tab.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 21, 0, 1));
        tab.push_back(idle(0, 21, 0, 1));
        tab.push_back(idle(1, 5, 1, 1));
        tab.push_back(idle(0, 5, 0, 0));

        foreach (tab[i]) step(tab[i], $sformatf("row%0d", i));

        // Reset during an FPU op discards its writeback
        step(mk(1, 22, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 5, 0, 0), "rst_fpu");
        step(idle(0, 5, 0, 1), "rst_c1");
        rv = idle(0, 0, 0, 0); rv.rst = 1; rv.chk = 0;
        step(rv, "rst_c2");
        for (int i = 0; i < LAT + 2; i++) begin
            step(idle(0, 0, 0, 0), $sformatf("post_rst%0d", i));
            check($sformatf("post_rst%0d busy", i), int'(busy), 0);
        end

        for (int n = 0; n < 3000; n++) begin
            rv.rst = ($urandom_range(0, 99) == 0);
            rv.v = ($urandom_range(0, 9) < 7);
            rv.rd = pick_reg(); rv.rs1 = pick_reg(); rv.rs2 = pick_reg();
            rv.fpu = ($urandom_range(0, 9) < 3);
            rv.a_en = 1'($urandom); rv.b_en = 1'($urandom);
            rv.rd_a = ($urandom_range(0, 3) == 0);
            rv.res = ($urandom_range(0, 3) != 0);
            rv.chk = 0; rv.e_ready = 0; rv.e_wbv = 0; rv.e_wbrd = 0; rv.e_wbf = 0; rv.e_fbusy = 0;
            step(rv, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
